// File: rtl/param_bank_pkg.sv
// Register map constants and helpers shared by the parameter bank and its slots.
// No logic of its own; no latency or backpressure.
package param_bank_pkg;

  localparam logic [1:0] OFS_ADDR = 2'd0;
  localparam logic [1:0] OFS_DATA = 2'd1;
  localparam logic [1:0] OFS_CMD  = 2'd2;

  localparam int CMD_COMMIT  = 0;
  localparam int CMD_DISCARD = 1;
  localparam int CMD_SNAP    = 2;
  localparam int CMD_CLRERR  = 3;

  localparam int STAT_PENDING = 0;
  localparam int STAT_ERR     = 1;

  localparam int AUTOINC_BIT = 15;

  function automatic logic [15:0] byte_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/param_bank_slot.sv
// One write parameter: shadow, active and dirty state with byte-lane writes; active and
// update pulse change one cycle after commit (or after a write in immediate mode); never stalls.
module param_bank_slot
  import param_bank_pkg::*;
#(
  parameter int DataWidth     = 16,
  parameter int ImmediateMode = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_vld,
  input  logic [1:0]           wr_be,
  input  logic [DataWidth-1:0] wr_dat,
  input  logic                 commit_vld,
  input  logic                 discard_vld,
  output logic [DataWidth-1:0] active_dat,
  output logic                 dirty,
  output logic                 update_vld
);

  logic [DataWidth-1:0] shadow_q, shadow_d;
  logic [DataWidth-1:0] active_q, active_d;
  logic                 dirty_q, dirty_d;
  logic                 update_q, update_d;
  logic [15:0]          mask16;
  logic [DataWidth-1:0] mask;

  always_comb begin
    mask16   = byte_mask(wr_be);
    mask     = mask16[DataWidth-1:0];
    shadow_d = shadow_q;
    active_d = active_q;
    dirty_d  = dirty_q;
    update_d = 1'b0;

    if (wr_vld) begin
      if (ImmediateMode != 0) begin
        active_d = (active_q & ~mask) | (wr_dat & mask);
        shadow_d = active_d;
        update_d = 1'b1;
      end else begin
        shadow_d = (shadow_q & ~mask) | (wr_dat & mask);
        dirty_d  = 1'b1;
      end
    end

    // Discard is applied before commit, so both together leave nothing to commit.
    if (discard_vld) begin
      shadow_d = active_q;
      dirty_d  = 1'b0;
    end else if (commit_vld && dirty_q) begin
      active_d = shadow_q;
      dirty_d  = 1'b0;
      update_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      dirty_q  <= 1'b0;
      update_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      dirty_q  <= dirty_d;
      update_q <= update_d;
    end
  end

  assign active_dat = active_q;
  assign dirty      = dirty_q;
  assign update_vld = update_q;

endmodule

// File: rtl/param_bank.sv
// Bus-mapped bank of shadowed write parameters with atomic commit and snapshotted read parameters.
// Read data is registered (one cycle after the access); every access completes in one cycle, no backpressure.
module param_bank
  import param_bank_pkg::*;
#(
  parameter int BaseAddr      = 'h0188,
  parameter int DataWidth     = 16,
  parameter int NumWrParams   = 8,
  parameter int NumRdParams   = 4,
  parameter int AddrWidth     = 4,
  parameter int ImmediateMode = 0
) (
  input  logic                             Clk_i,
  input  logic                             Reset_i,
  input  logic [13:0]                      PerAddr_i,
  input  logic [15:0]                      PerDIn_i,
  input  logic [1:0]                       PerWr_i,
  input  logic                             PerEn_i,
  output logic [15:0]                      PerDOut_o,
  output logic [NumWrParams*DataWidth-1:0] Params_o,
  output logic [NumWrParams-1:0]           ParamUpdate_o,
  input  logic [NumRdParams*DataWidth-1:0] ParamsIn_i
);

  localparam logic [13:0] BASE = 14'(BaseAddr);

  logic [13:0] ofs;
  logic [1:0]  reg_ofs;
  logic        sel, is_wr, is_rd;
  logic        addr_wr, data_wr, data_rd, cmd_wr;
  logic        commit, discard, snap_take;
  logic        ptr_ok_wr, ptr_ok_rd;

  logic [AddrWidth-1:0] ptr_q, ptr_d;
  logic                 autoinc_q, autoinc_d;
  logic                 err_q, err_d;
  logic [15:0]          dout_q, dout_d;
  logic [DataWidth-1:0] snap_q [NumRdParams];
  logic [DataWidth-1:0] snap_d [NumRdParams];
  logic [DataWidth-1:0] rd_data;
  logic [NumWrParams-1:0] dirty_w;

  // Unsigned subtraction wraps, so one compare covers both ends of the window.
  assign ofs     = PerAddr_i - BASE;
  assign reg_ofs = ofs[1:0];
  assign sel     = PerEn_i && (ofs < 14'd3);
  assign is_wr   = sel && (PerWr_i != 2'b00);
  assign is_rd   = sel && (PerWr_i == 2'b00);

  assign addr_wr   = is_wr && (reg_ofs == OFS_ADDR);
  assign data_wr   = is_wr && (reg_ofs == OFS_DATA);
  assign data_rd   = is_rd && (reg_ofs == OFS_DATA);
  assign cmd_wr    = is_wr && (reg_ofs == OFS_CMD) && PerWr_i[0];
  assign commit    = cmd_wr && PerDIn_i[CMD_COMMIT];
  assign discard   = cmd_wr && PerDIn_i[CMD_DISCARD];
  assign snap_take = addr_wr || (cmd_wr && PerDIn_i[CMD_SNAP]);

  assign ptr_ok_wr = int'(ptr_q) < NumWrParams;
  assign ptr_ok_rd = int'(ptr_q) < NumRdParams;

  always_comb begin
    ptr_d     = ptr_q;
    autoinc_d = autoinc_q;
    err_d     = err_q;
    dout_d    = '0;
    snap_d    = snap_q;
    rd_data   = '0;

    for (int j = 0; j < NumRdParams; j++) begin
      if (ptr_q == AddrWidth'(j)) rd_data = snap_q[j];
    end

    if (addr_wr) begin
      if (PerWr_i[0]) ptr_d = PerDIn_i[AddrWidth-1:0];
      if (PerWr_i[1]) autoinc_d = PerDIn_i[AUTOINC_BIT];
    end

    if ((data_wr || data_rd) && autoinc_q) ptr_d = ptr_q + AddrWidth'(1);

    if ((data_wr && !ptr_ok_wr) || (data_rd && !ptr_ok_rd)) err_d = 1'b1;
    if (cmd_wr && PerDIn_i[CMD_CLRERR]) err_d = 1'b0;

    if (snap_take) begin
      for (int j = 0; j < NumRdParams; j++) snap_d[j] = ParamsIn_i[j*DataWidth +: DataWidth];
    end

    if (is_rd) begin
      case (reg_ofs)
        OFS_ADDR: begin
          dout_d[AddrWidth-1:0] = ptr_q;
          dout_d[AUTOINC_BIT]   = autoinc_q;
        end
        OFS_DATA: if (ptr_ok_rd) dout_d[DataWidth-1:0] = rd_data;
        OFS_CMD: begin
          dout_d[STAT_PENDING] = |dirty_w;
          dout_d[STAT_ERR]     = err_q;
          dout_d[15:8]         = 8'(NumWrParams);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      ptr_q     <= '0;
      autoinc_q <= 1'b0;
      err_q     <= 1'b0;
      dout_q    <= '0;
      for (int j = 0; j < NumRdParams; j++) snap_q[j] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      autoinc_q <= autoinc_d;
      err_q     <= err_d;
      dout_q    <= dout_d;
      snap_q    <= snap_d;
    end
  end

  assign PerDOut_o = dout_q;

  for (genvar i = 0; i < NumWrParams; i++) begin : g_slot
    param_bank_slot #(
      .DataWidth    (DataWidth),
      .ImmediateMode(ImmediateMode)
    ) u_slot (
      .clk        (Clk_i),
      .rst        (Reset_i),
      .wr_vld     (data_wr && (ptr_q == AddrWidth'(i))),
      .wr_be      (PerWr_i),
      .wr_dat     (PerDIn_i[DataWidth-1:0]),
      .commit_vld (commit),
      .discard_vld(discard),
      .active_dat (Params_o[i*DataWidth +: DataWidth]),
      .dirty      (dirty_w[i]),
      .update_vld (ParamUpdate_o[i])
    );
  end

endmodule

// File: tb/tb_param_bank.sv
// Random and directed bus traffic against two banks (shadowed and immediate) checked by a scoreboard.
module tb_param_bank;

  localparam int NW = 8;
  localparam int NR = 4;
  localparam logic [13:0] BASE = 14'h0188;

  logic          clk = 1'b0;
  logic          Reset_i = 1'b1;
  logic [13:0]   PerAddr_i = '0;
  logic [15:0]   PerDIn_i = '0;
  logic [1:0]    PerWr_i = '0;
  logic          PerEn_i = 1'b0;
  logic [NR*16-1:0] ParamsIn_i = '0;
  logic [15:0]   dout0, dout1;
  logic [NW*16-1:0] par0, par1;
  logic [NW-1:0] upd0, upd1;

  always #5 clk = ~clk;

  param_bank #(.ImmediateMode(0)) dut0 (
    .Clk_i(clk), .Reset_i(Reset_i), .PerAddr_i(PerAddr_i), .PerDIn_i(PerDIn_i),
    .PerWr_i(PerWr_i), .PerEn_i(PerEn_i), .PerDOut_o(dout0), .Params_o(par0),
    .ParamUpdate_o(upd0), .ParamsIn_i(ParamsIn_i));

  param_bank #(.ImmediateMode(1)) dut1 (
    .Clk_i(clk), .Reset_i(Reset_i), .PerAddr_i(PerAddr_i), .PerDIn_i(PerDIn_i),
    .PerWr_i(PerWr_i), .PerEn_i(PerEn_i), .PerDOut_o(dout1), .Params_o(par1),
    .ParamUpdate_o(upd1), .ParamsIn_i(ParamsIn_i));

  typedef struct packed {
    logic [15:0]      dout0, dout1;
    logic [NW*16-1:0] par0, par1;
    logic [NW-1:0]    upd0, upd1;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  // Reference state: index 0 = shadowed bank, 1 = immediate bank.
  logic [15:0] m_act [2][NW];
  logic [15:0] m_sh  [2][NW];
  bit          m_dirty [2][NW];
  logic [15:0] m_snap [NR];
  int          m_ptr;
  bit          m_ai, m_err;
  logic [NR*16-1:0] pin_nxt = '0;

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NW; i++) begin
        m_act[k][i] = '0; m_sh[k][i] = '0; m_dirty[k][i] = 0;
      end
    for (int j = 0; j < NR; j++) m_snap[j] = '0;
    m_ptr = 0; m_ai = 0; m_err = 0;
  endtask

  task automatic take_snap();
    for (int j = 0; j < NR; j++) m_snap[j] = pin_nxt[j*16 +: 16];
  endtask

  // Drive one bus cycle and push what the outputs must show after the next clock edge.
  task automatic op(input logic r, input logic e, input logic [13:0] a,
                    input logic [15:0] d, input logic [1:0] w);
    exp_t x;
    logic [15:0] m;
    logic [15:0] rdv [2];
    logic [NW-1:0] u [2];
    int o;
    bit pend;
    @(negedge clk);
    Reset_i = r; PerEn_i = e; PerAddr_i = a; PerDIn_i = d; PerWr_i = w;
    ParamsIn_i = pin_nxt;
    rdv[0] = '0; rdv[1] = '0; u[0] = '0; u[1] = '0;
    o = int'(a) - int'(BASE);
    m = {{8{w[1]}}, {8{w[0]}}};
    if (r) begin
      model_reset();
    end else if (e && o >= 0 && o <= 2) begin
      if (w != 2'b00) begin
        if (o == 0) begin
          if (w[0]) m_ptr = int'(d[3:0]);
          if (w[1]) m_ai = d[15];
          take_snap();
        end else if (o == 1) begin
          if (m_ptr < NW) begin
            m_sh[0][m_ptr] = (m_sh[0][m_ptr] & ~m) | (d & m);
            m_dirty[0][m_ptr] = 1;
            m_act[1][m_ptr] = (m_act[1][m_ptr] & ~m) | (d & m);
            m_sh[1][m_ptr] = m_act[1][m_ptr];
            u[1][m_ptr] = 1'b1;
          end else begin
            m_err = 1;
          end
          if (m_ai) m_ptr = (m_ptr + 1) % 16;
        end else if (w[0]) begin
          if (d[3]) m_err = 0;
          for (int k = 0; k < 2; k++)
            for (int i = 0; i < NW; i++) begin
              if (d[1]) begin
                m_sh[k][i] = m_act[k][i]; m_dirty[k][i] = 0;
              end else if (d[0] && m_dirty[k][i]) begin
                m_act[k][i] = m_sh[k][i]; m_dirty[k][i] = 0; u[k][i] = 1'b1;
              end
            end
          if (d[2]) take_snap();
        end
      end else begin
        if (o == 0) begin
          rdv[0] = {m_ai, 11'b0, 4'(m_ptr)};
          rdv[1] = rdv[0];
        end else if (o == 1) begin
          if (m_ptr < NR) rdv[0] = m_snap[m_ptr];
          else m_err = 1;
          rdv[1] = rdv[0];
          if (m_ai) m_ptr = (m_ptr + 1) % 16;
        end else begin
          for (int k = 0; k < 2; k++) begin
            pend = 0;
            for (int i = 0; i < NW; i++) pend |= m_dirty[k][i];
            rdv[k] = {8'(NW), 6'b0, m_err, pend};
          end
        end
      end
    end
    x.dout0 = rdv[0]; x.dout1 = rdv[1]; x.upd0 = u[0]; x.upd1 = u[1];
    for (int i = 0; i < NW; i++) begin
      x.par0[i*16 +: 16] = m_act[0][i];
      x.par1[i*16 +: 16] = m_act[1][i];
    end
    q.push_back(x);
  endtask

  task automatic bw(input int o, input logic [15:0] d, input logic [1:0] w);
    op(1'b0, 1'b1, BASE + 14'(o), d, w);
  endtask

  task automatic br(input int o);
    op(1'b0, 1'b1, BASE + 14'(o), 16'h0, 2'b00);
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 14'h0, 16'h0, 2'b00);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("dout_shadowed", 128'(dout0), 128'(x.dout0));
        chk("dout_immediate", 128'(dout1), 128'(x.dout1));
        chk("params_shadowed", par0, x.par0);
        chk("params_immediate", par1, x.par1);
        chk("update_shadowed", 128'(upd0), 128'(x.upd0));
        chk("update_immediate", 128'(upd1), 128'(x.upd1));
      end
    end
  end

  initial begin : driver
    logic [13:0] ra;
    logic [15:0] rd;
    logic [1:0]  rw;
    int          s;
    model_reset();
    repeat (2) @(posedge clk);
    op(1'b1, 1'b0, 14'h0, 16'h0, 2'b00);
    br(0); br(1); br(2); idle();

    bw(0, 16'h8002, 2'b11); bw(1, 16'h1234, 2'b11); bw(1, 16'h5678, 2'b11); br(2);
    bw(2, 16'h0001, 2'b11); idle(); idle(); br(2);

    bw(0, 16'h0001, 2'b11); bw(1, 16'hAAAA, 2'b11); bw(2, 16'h0001, 2'b11);
    bw(1, 16'hFFFF, 2'b01); bw(2, 16'h0001, 2'b11); idle();

    bw(0, 16'h800F, 2'b11); bw(1, 16'h1111, 2'b11); bw(1, 16'h2222, 2'b11);
    br(2); br(0); bw(2, 16'h0008, 2'b11); br(2);

    pin_nxt = 64'h0000_0000_0000_00C3;
    bw(0, 16'h8000, 2'b11);
    pin_nxt = 64'h0000_0000_0000_0011;
    br(1); br(0); idle();

    bw(0, 16'h8004, 2'b11); bw(1, 16'h7777, 2'b11); bw(2, 16'h0002, 2'b11); br(2); idle();
    bw(2, 16'h0003, 2'b11); idle();

    bw(0, 16'h8005, 2'b11); bw(1, 16'hBEEF, 2'b11);
    op(1'b1, 1'b1, BASE + 14'd1, 16'hCAFE, 2'b11); idle(); br(2);

    for (int n = 0; n < 1500; n++) begin
      pin_nxt = {$urandom, $urandom};
      s  = int'($urandom_range(0, 99));
      ra = BASE + 14'($urandom_range(0, 2));
      if (s < 4) ra = BASE + 14'd3;
      else if (s < 7) ra = BASE - 14'd1;
      rw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 4) rw = 2'b00;
      rd = 16'($urandom);
      op(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) != 0), ra, rd, rw);
    end
    idle();

    for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
